// File: rtl/ps2_io_pkg.sv
// ---------------------------------------------------------------------------
// ps2_io_pkg
// Shared definitions for the PS/2 I/O controller:
//   - register offsets relative to BASE_ADDR
//   - STATUS / CTRL bit positions
//   - receive-path FSM state encoding
// ---------------------------------------------------------------------------
package ps2_io_pkg;

  localparam logic [31:0] OFS_DATA   = 32'h0;
  localparam logic [31:0] OFS_STATUS = 32'h4;
  localparam logic [31:0] OFS_CTRL   = 32'h8;

  // STATUS fields
  localparam int ST_EN       = 0;
  localparam int ST_EMPTY    = 1;
  localparam int ST_FULL     = 2;
  localparam int ST_OVF      = 3;
  localparam int ST_BCNT_LSB = 4;  // [5:4]  partial byte count
  localparam int ST_FCNT_LSB = 8;  // [12:8] FIFO word count

  // CTRL fields
  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVF_CLR = 2;
  localparam int CTRL_IRQ_EN  = 3;

  typedef enum logic [1:0] {
    DIS   = 2'd0,
    RECV  = 2'd1,
    PUSH  = 2'd2,
    STALL = 2'd3
  } state_e;

endpackage

// File: rtl/ps2_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps2_io_ctrl_if
// Processor I/O bus seen by the PS/2 controller.
//   cpu_addr   : bus address
//   cpu_rd     : one-cycle read strobe
//   cpu_wr     : one-cycle write strobe
//   cpu_wdata  : write data
//   cpu_rdata  : registered read data
//   cpu_rvalid : one-cycle pulse, cycle after a decoded read
// master = processor side, slave = controller side.
// ---------------------------------------------------------------------------
interface ps2_io_ctrl_if;
  logic [31:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    input  cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
    output cpu_rdata, cpu_rvalid
  );
endinterface

// File: rtl/ps2_word_fifo.sv
// ---------------------------------------------------------------------------
// ps2_word_fifo
// Synchronous word FIFO, DEPTH a power of two.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous empty (flush), wins over push/pop
//   push, din  : write request and data (accepted if not full, or if a pop
//                happens in the same cycle)
//   pop, dout  : read request, dout is the current head (show-ahead)
//   full, empty, count : occupancy, count width clog2(DEPTH)+1
// ---------------------------------------------------------------------------
module ps2_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a push on a full FIFO is legal then.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by the pointers/count,
  // so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_io_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_io_ctrl
// Bridges the PS/2 byte receiver to the processor I/O bus: packs bytes into
// 32-bit words (first byte in [7:0]), queues them in a word FIFO and serves
// DATA (+0x0, pop on read), STATUS (+0x4) and CTRL (+0x8) registers.
//   clk, reset         : clock, synchronous active-high reset
//   rx_done_tick       : one-cycle pulse, rx_dout valid
//   rx_dout            : received byte
//   rx_en              : receiver enable (RECV/PUSH states)
//   bus                : processor bus, slave modport of ps2_io_ctrl_if
//   listo              : FIFO non-empty
//   ovf                : sticky overflow (byte arrived while a word was held)
//   irq                : only with PS2_IRQ_EN defined; registered
//                        irq_en & (listo | ovf), irq_en is CTRL[3]
// ---------------------------------------------------------------------------
module ps2_io_ctrl
  import ps2_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_AAA0,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done_tick,
  input  logic [7:0]    rx_dout,
  output logic          rx_en,
  ps2_io_ctrl_if.slave  bus,
  output logic          listo,
  output logic          ovf
`ifdef PS2_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IW-1:0] TO_MAX = IW'(TIMEOUT_CYC);

  state_e        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [31:0]   word_q, word_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          en_q, flush_q, ovf_q, rvalid_q;
  logic [31:0]   rdata_q;
  logic [31:0]   status_w, rd_mux;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_dout;
  logic [CW-1:0] fifo_count;

  // ---- bus decode --------------------------------------------------------
  logic hit_data, hit_status, hit_ctrl, rd_hit, ctrl_wr, ovf_set;

  assign hit_data   = (bus.cpu_addr == BASE_ADDR + OFS_DATA);
  assign hit_status = (bus.cpu_addr == BASE_ADDR + OFS_STATUS);
  assign hit_ctrl   = (bus.cpu_addr == BASE_ADDR + OFS_CTRL);
  assign rd_hit     = bus.cpu_rd && (hit_data || hit_status || hit_ctrl);
  assign ctrl_wr    = bus.cpu_wr && hit_ctrl;
  assign fifo_pop   = bus.cpu_rd && hit_data && !fifo_empty;

  // A byte is lost whenever a complete word is still waiting for the FIFO;
  // a flush in the same cycle drops it silently instead.
  assign ovf_set = rx_done_tick && !flush_q &&
                   ((state_q == PUSH) || (state_q == STALL));

  ps2_word_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush_q),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (word_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---- receive FSM -------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    fifo_push = 1'b0;

    if (flush_q || !en_q) begin
      // Partial (or held) word is discarded; the FIFO is cleared only by flush.
      state_d = en_q ? RECV : DIS;
      bcnt_d  = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        DIS:  state_d = RECV;
        RECV: begin
          if (rx_done_tick) begin
            word_d[{bcnt_q[1:0], 3'b000} +: 8] = rx_dout;
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd3) state_d = PUSH;
          end else if ((TIMEOUT_CYC != 0) && (bcnt_q != '0) && (idle_q == TO_MAX)) begin
            // Unfilled bytes are already zero: word_q is cleared after each push.
            state_d = PUSH;
          end
        end
        PUSH: begin
          if (!fifo_full || fifo_pop) begin
            fifo_push = 1'b1;
            bcnt_d    = '0;
            word_d    = '0;
            state_d   = RECV;
          end else begin
            state_d = STALL;
          end
        end
        STALL: if (!fifo_full) state_d = PUSH;
        default: state_d = DIS;
      endcase
    end

    // Idle counter: restarts on every byte, saturates at TIMEOUT_CYC.
    if (state_q != RECV || rx_done_tick) idle_d = '0;
    else if (idle_q != TO_MAX)           idle_d = idle_q + IW'(1);
    else                                 idle_d = idle_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIS;
      bcnt_q  <= '0;
      word_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      idle_q  <= idle_d;
    end
  end

  // ---- registers ---------------------------------------------------------
`ifdef PS2_IRQ_EN
  logic irq_en_q, irq_q;
`else
  logic irq_en_q;
  assign irq_en_q = 1'b0;
`endif

  always_comb begin
    status_w                       = '0;
    status_w[ST_EN]                = en_q;
    status_w[ST_EMPTY]             = fifo_empty;
    status_w[ST_FULL]              = fifo_full;
    status_w[ST_OVF]               = ovf_q;
    status_w[ST_BCNT_LSB +: 2]     = bcnt_q[1:0];
    status_w[ST_FCNT_LSB +: 5]     = 5'(fifo_count);

    rd_mux = '0;
    if (hit_data)        rd_mux = fifo_empty ? 32'h0 : fifo_dout;
    else if (hit_status) rd_mux = status_w;
    else if (hit_ctrl) begin
      // Flush and ovf-clear are strobes and always read back as 0.
      rd_mux[CTRL_EN]     = en_q;
      rd_mux[CTRL_IRQ_EN] = irq_en_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= 1'b0;
      flush_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_hit;
      if (rd_hit)  rdata_q <= rd_mux;
      flush_q  <= ctrl_wr && bus.cpu_wdata[CTRL_FLUSH];
      if (ctrl_wr) en_q <= bus.cpu_wdata[CTRL_EN];
      // A new overflow in the same cycle as a clear is kept.
      if (ovf_set)                                     ovf_q <= 1'b1;
      else if (ctrl_wr && bus.cpu_wdata[CTRL_OVF_CLR]) ovf_q <= 1'b0;
    end
  end

`ifdef PS2_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= bus.cpu_wdata[CTRL_IRQ_EN];
      irq_q <= irq_en_q && (!fifo_empty || ovf_q);
    end
  end
  assign irq = irq_q;
`endif

  assign rx_en          = (state_q == RECV) || (state_q == PUSH);
  assign listo          = !fifo_empty;
  assign ovf            = ovf_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_rvalid = rvalid_q;

endmodule

// File: tb/tb_ps2_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_io_ctrl
// Directed bench for ps2_io_ctrl (FIFO_DEPTH=4, TIMEOUT_CYC=10). Register
// reads push their expected value into a queue; a monitor on the falling
// edge pops and compares whenever cpu_rvalid is high. Connects irq when
// PS2_IRQ_EN is defined.
// ---------------------------------------------------------------------------
module tb_ps2_io_ctrl;

  localparam logic [31:0] BASE = 32'h0000_AAA0;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] rx_byte;
  logic       rx_en, listo, ovf;
`ifdef PS2_IRQ_EN
  logic       irq;
`endif

  ps2_io_ctrl_if bus ();

  ps2_io_ctrl #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (tick),
    .rx_dout      (rx_byte),
    .rx_en        (rx_en),
    .bus          (bus),
    .listo        (listo),
    .ovf          (ovf)
`ifdef PS2_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every read response is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.cpu_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h, expected no response", bus.cpu_rdata);
      end else begin
        e = exp_q.pop_front();
        check(e.name, bus.cpu_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_rd(input logic [31:0] ofs, input string name, input logic [31:0] exp);
    exp_q.push_back('{name, exp});
    @(posedge clk); #1;
    bus.cpu_addr = BASE + ofs;
    bus.cpu_rd   = 1'b1;
    @(posedge clk); #1;
    bus.cpu_rd   = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] ofs, input logic [31:0] data);
    @(posedge clk); #1;
    bus.cpu_addr  = BASE + ofs;
    bus.cpu_wdata = data;
    bus.cpu_wr    = 1'b1;
    @(posedge clk); #1;
    bus.cpu_wr    = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    tick    = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    tick    = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic probe(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    reset         = 1'b1;
    tick          = 1'b0;
    rx_byte       = '0;
    bus.cpu_addr  = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_wdata = '0;
    cycles(3);
    @(negedge clk);
    probe("reset_rx_en",  rx_en,          0);
    probe("reset_listo",  listo,          0);
    probe("reset_ovf",    ovf,            0);
    probe("reset_rdata",  bus.cpu_rdata,  0);
    probe("reset_rvalid", bus.cpu_rvalid, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // --- basic 4-byte word --------------------------------------------------
    bus_wr(32'h8, 32'h1);
    cycles(2);
    @(negedge clk) probe("rx_en_after_enable", rx_en, 1);
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    cycles(3);
    @(negedge clk) probe("listo_word1", listo, 1);
    bus_rd(32'h4, "status_one_word", 32'h0000_0101);
    bus_rd(32'h0, "data_word1",      32'h2321_321C);
    cycles(2);
    @(negedge clk) probe("listo_after_pop", listo, 0);

    // --- idle timeout flushes a partial word --------------------------------
    send(8'hF0); send(8'h1C);
    cycles(5);
    @(negedge clk) probe("no_early_timeout", listo, 0);
    cycles(10);
    @(negedge clk) probe("listo_after_timeout", listo, 1);
    bus_rd(32'h0, "data_timeout_word", 32'h0000_1CF0);

    // --- fill, stall, overflow, release -------------------------------------
    send_word(32'h0403_0201);
    send_word(32'h1413_1211);
    send_word(32'h2423_2221);
    send_word(32'h3433_3231);
    send_word(32'h4443_4241);
    cycles(3);
    @(negedge clk) probe("rx_en_in_stall", rx_en, 0);
    send(8'h99);
    @(negedge clk) probe("ovf_tick_in_stall", ovf, 1);
    bus_rd(32'h4, "status_stall",   32'h0000_040D);
    bus_rd(32'h0, "data_w0",        32'h0403_0201);
    cycles(4);
    @(negedge clk) probe("rx_en_after_release", rx_en, 1);
    bus_rd(32'h4, "status_refill",  32'h0000_040D);
    bus_rd(32'h0, "data_w1",        32'h1413_1211);
    bus_rd(32'h0, "data_w2",        32'h2423_2221);
    bus_rd(32'h0, "data_w3",        32'h3433_3231);
    bus_rd(32'h0, "data_held_word", 32'h4443_4241);

    // --- empty read and unmapped address -------------------------------------
    bus_rd(32'h0, "data_empty",     32'h0);
    bus_rd(32'h4, "status_empty",   32'h0000_000B);
    @(posedge clk); #1;
    bus.cpu_addr = BASE + 32'hC;
    bus.cpu_rd   = 1'b1;
    @(posedge clk); #1;
    bus.cpu_rd   = 1'b0;
    @(negedge clk) probe("unmapped_rvalid", bus.cpu_rvalid, 0);

    // --- flush and overflow clear -------------------------------------------
    send_word(32'h0D0C_0B0A);
    cycles(2);
    send(8'hAA); send(8'hBB);
    bus_rd(32'h4, "status_partial2", 32'h0000_0129);
    bus_wr(32'h8, 32'h3);
    cycles(2);
    @(negedge clk) probe("listo_after_flush", listo, 0);
    bus_rd(32'h4, "status_flushed",  32'h0000_000B);
    bus_wr(32'h8, 32'h5);
    @(negedge clk) probe("ovf_cleared", ovf, 0);
    bus_rd(32'h4, "status_ovf_clr",  32'h0000_0003);
    bus_rd(32'h8, "ctrl_readback",   32'h0000_0001);

    // --- reset mid-word ------------------------------------------------------
    send_word(32'h5566_7788);
    cycles(2);
    send(8'h11); send(8'h22); send(8'h33);
    @(posedge clk); #1;
    reset = 1'b1;
    cycles(2);
    @(negedge clk);
    probe("rst2_rx_en",  rx_en,          0);
    probe("rst2_listo",  listo,          0);
    probe("rst2_rdata",  bus.cpu_rdata,  0);
    probe("rst2_rvalid", bus.cpu_rvalid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_rd(32'h4, "status_after_reset", 32'h0000_0002);
    bus_rd(32'h8, "ctrl_after_reset",   32'h0000_0000);
    bus_wr(32'h8, 32'h1);
    cycles(2);
    send_word(32'hD4C3_B2A1);
    cycles(3);
    bus_rd(32'h0, "data_after_reset",   32'hD4C3_B2A1);

    cycles(5);
    probe("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_io_ctrl.md
Name: ps2_io_ctrl

Overview:
Controller between the PS/2 byte receiver and the processor I/O bus.
- Gates the receiver via rx_en.
- Packs received bytes into 32-bit words and queues them in a small FIFO.
- Serves memory-mapped DATA/STATUS/CTRL registers.
- Raises `listo` while words are pending.
- Replaces the ad-hoc fixed-address buffer path with a sequenced, flow-controlled interface.

Parameters:
- BASE_ADDR, 32'h0000_AAA0, word-aligned base. Register map: DATA +0x0, STATUS +0x4, CTRL +0x8.
- FIFO_DEPTH, 4, word FIFO depth; power of two, 2..16.
- TIMEOUT_CYC, 100000, idle clocks before a partial word is flushed; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_done_tick  in  1  one-cycle pulse: rx_dout valid
- rx_dout  in  8  received scan-code byte
- rx_en  out  1  receiver enable
- cpu_addr  in  32  bus address
- cpu_rd  in  1  read strobe, one cycle
- cpu_wr  in  1  write strobe, one cycle
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, registered
- cpu_rvalid  out  1  pulses one cycle after a decoded cpu_rd
- listo  out  1  FIFO non-empty
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset values: rx_en=0, cpu_rdata=0, cpu_rvalid=0, listo=0, ovf=0, CTRL=0, FIFO empty, byte count 0, state DIS.
- Reset mid-word discards the partial word and clears all state.
- Address decode: exact match to BASE_ADDR+{0,4,8}. Other addresses are ignored; cpu_rvalid stays 0.
- cpu_rvalid and cpu_rdata are updated in the cycle after cpu_rd (1-cycle latency).
- DATA (read-only): returns the FIFO head and pops it. When empty it returns 0 and does not pop.
- STATUS (read-only) bit fields:
  - [0] enable
  - [1] empty
  - [2] full
  - [3] ovf
  - [5:4] partial byte count
  - [12:8] FIFO count
  - other bits 0
- CTRL (read/write):
  - [0] enable
  - [1] flush: self-clearing; empties the FIFO and partial word the next cycle
  - [2] ovf clear: write-1-to-clear, reads 0
- Packing order: byte k of a word goes to bits [8k+7:8k]; the first received byte lands in [7:0].
- FSM states:
  - DIS: rx_en=0, ticks ignored. Go to RECV when enable=1.
  - RECV: rx_en=1. Each tick stores a byte and increments the byte count. On the 4th byte go to PUSH. If the byte count >0 and the idle counter reaches TIMEOUT_CYC, go to PUSH with unfilled bytes set to 0.
  - PUSH: rx_en=1. If FIFO not full, or a DATA pop occurs this cycle, write the word, clear the byte count, return to RECV. Otherwise go to STALL.
  - STALL: rx_en=0. Hold the word. Go to PUSH once the FIFO is not full.
- Disable (enable=0) from any state goes to DIS next cycle; the FIFO is kept and the partial word is discarded.
- The idle counter resets on every tick and saturates at TIMEOUT_CYC.
- A tick arriving in PUSH or STALL drops the byte and sets ovf=1.
- Simultaneous pop and push on a full FIFO: both occur; count is unchanged.
- Simultaneous flush and tick: flush wins and the byte is dropped; ovf is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
PS2_IRQ_EN.
- Defined: adds output port `irq`, width 1. CTRL[3] is irq_en (read/write). irq = irq_en & (listo | ovf), registered.
- Undefined: no irq port; CTRL[3] reads 0 and writes are ignored.

Decomposition:
- Package ps2_io_pkg holds:
  - register offsets OFS_DATA/OFS_STATUS/OFS_CTRL
  - STATUS/CTRL bit-position constants
  - FSM state enum {DIS, RECV, PUSH, STALL}
- One sub-module: ps2_word_fifo. It is a synchronous FIFO with push, pop, din, dout, full, empty and count, using simultaneous-push/pop-safe logic.

Test Plan:
- Write CTRL=1; send ticks 0x1C,0x32,0x21,0x23 → listo=1, STATUS count=1; DATA read returns 0x2321321C; then listo=0.
- Send 2 bytes 0xF0,0x1C, then 10 idle cycles, with TIMEOUT_CYC=10 → pushed word 0x00001CF0.
- Fill 4 words (FIFO_DEPTH=4), then send a 5th word → FSM enters STALL, rx_en=0. A tick in STALL gives ovf=1. One DATA read → the held word is pushed and rx_en returns to 1.
- Read DATA on an empty FIFO → cpu_rdata=0, cpu_rvalid=1, count unchanged. Read an unmapped address (BASE+0xC) → cpu_rvalid=0.
- Two bytes pending, write CTRL=0x3 → FIFO empty, STATUS[5:4]=0. Write CTRL=0x5 → ovf cleared.
- Assert reset after 3 bytes → all outputs at reset values. Next full word packs from byte 0.
